// File: rtl/rename_map.sv
// Register rename map with branch checkpoints.
// Each architectural register holds the tag of the reservation station that
// will produce its next value; tag 0 means the register file value is current.
// Checkpoint slots snapshot the table for mispredict recovery and stay
// coherent with commits so a restored table never holds a stale tag.
module rename_map #(
   parameter int REG_N  = 32,
   parameter int IDX_W  = 5,
   parameter int TAG_W  = 4,
   parameter int CKPT_N = 2,
   parameter int CKPT_W = (CKPT_N > 1) ? $clog2(CKPT_N) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic [IDX_W-1:0]  iss_dst,
   input  logic [TAG_W-1:0]  iss_tag,
   input  logic              cmt_valid,
   input  logic [IDX_W-1:0]  cmt_dst,
   input  logic [TAG_W-1:0]  cmt_tag,
   input  logic [IDX_W-1:0]  rs1,
   input  logic [IDX_W-1:0]  rs2,
   output logic [TAG_W-1:0]  qj,
   output logic [TAG_W-1:0]  qk,
   input  logic              ckpt_save,
   input  logic [CKPT_W-1:0] ckpt_id,
   input  logic              ckpt_restore,
   input  logic [CKPT_W-1:0] rst_id,
   input  logic              flush,
   output logic [CKPT_N-1:0] ckpt_vld,
   output logic [IDX_W:0]    busy_cnt
);

   logic [TAG_W-1:0]  map_reg   [REG_N];
   logic [TAG_W-1:0]  map_next  [REG_N];
   logic [TAG_W-1:0]  ckpt_reg  [CKPT_N][REG_N];
   logic [TAG_W-1:0]  ckpt_next [CKPT_N][REG_N];
   logic [CKPT_N-1:0] vld_reg, vld_next;
   logic [IDX_W:0]    cnt_reg, cnt_next;
   logic              iss_ok, restore_ok, save_ok;

   // Operand lookups read the registered table only; no same-cycle bypass.
   assign qj       = map_reg[rs1];
   assign qk       = map_reg[rs2];
   assign ckpt_vld = vld_reg;
   assign busy_cnt = cnt_reg;

   // Qualify requests: register 0 and tag 0 never get renamed, and only a
   // valid in-range slot can be restored; a live restore pre-empts any save.
   always_comb begin
      iss_ok     = iss_valid && (iss_dst != '0) && (iss_tag != '0);
      restore_ok = ckpt_restore && (32'(rst_id) < CKPT_N) && vld_reg[rst_id];
      save_ok    = ckpt_save && (32'(ckpt_id) < CKPT_N) && !restore_ok;
   end

   // Next-state for the table, the checkpoint slots, valid bits and busy count.
   always_comb begin
      for (int r = 0; r < REG_N; r++) begin
         map_next[r] = restore_ok ? ckpt_reg[rst_id][r] : map_reg[r];
      end
      // Commit clears only if no younger instruction renamed the register;
      // the check is made against whichever table is about to be installed.
      if (cmt_valid && (map_next[cmt_dst] == cmt_tag)) begin
         map_next[cmt_dst] = '0;
      end
      // Issue overrides a same-index commit; it is lost on a restore.
      if (iss_ok && !restore_ok) begin
         map_next[iss_dst] = iss_tag;
      end

      vld_next = vld_reg;
      for (int s = 0; s < CKPT_N; s++) begin
         for (int r = 0; r < REG_N; r++) begin
            ckpt_next[s][r] = ckpt_reg[s][r];
         end
         if (cmt_valid && vld_reg[s] && (ckpt_reg[s][cmt_dst] == cmt_tag)) begin
            ckpt_next[s][cmt_dst] = '0;
         end
      end

      if (restore_ok) begin
         vld_next[rst_id] = 1'b0;
      end else if (save_ok) begin
         vld_next[ckpt_id] = 1'b1;
         for (int r = 0; r < REG_N; r++) begin
            ckpt_next[ckpt_id][r] = map_next[r];
         end
      end

      if (flush) begin
         vld_next = '0;
         for (int r = 0; r < REG_N; r++) begin
            map_next[r] = '0;
         end
         for (int s = 0; s < CKPT_N; s++) begin
            for (int r = 0; r < REG_N; r++) begin
               ckpt_next[s][r] = '0;
            end
         end
      end

      cnt_next = '0;
      for (int r = 0; r < REG_N; r++) begin
         cnt_next = cnt_next + {{IDX_W{1'b0}}, (map_next[r] != '0)};
      end
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < REG_N; r++) begin
            map_reg[r] <= '0;
         end
         for (int s = 0; s < CKPT_N; s++) begin
            for (int r = 0; r < REG_N; r++) begin
               ckpt_reg[s][r] <= '0;
            end
         end
         vld_reg <= '0;
         cnt_reg <= '0;
      end else begin
         for (int r = 0; r < REG_N; r++) begin
            map_reg[r] <= map_next[r];
         end
         for (int s = 0; s < CKPT_N; s++) begin
            for (int r = 0; r < REG_N; r++) begin
               ckpt_reg[s][r] <= ckpt_next[s][r];
            end
         end
         vld_reg <= vld_next;
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: tb/tb_rename_map.sv
// Self-checking bench for rename_map: directed vector table, a reset/flush
// sequence, and randomized traffic against a behavioural model.
module tb_rename_map;
   localparam int REG_N  = 32;
   localparam int IDX_W  = 5;
   localparam int TAG_W  = 4;
   localparam int CKPT_N = 2;
   localparam int CKPT_W = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              iss_valid = 1'b0;
   logic [IDX_W-1:0]  iss_dst = '0;
   logic [TAG_W-1:0]  iss_tag = '0;
   logic              cmt_valid = 1'b0;
   logic [IDX_W-1:0]  cmt_dst = '0;
   logic [TAG_W-1:0]  cmt_tag = '0;
   logic [IDX_W-1:0]  rs1 = '0;
   logic [IDX_W-1:0]  rs2 = '0;
   logic [TAG_W-1:0]  qj, qk;
   logic              ckpt_save = 1'b0;
   logic [CKPT_W-1:0] ckpt_id = '0;
   logic              ckpt_restore = 1'b0;
   logic [CKPT_W-1:0] rst_id = '0;
   logic              flush = 1'b0;
   logic [CKPT_N-1:0] ckpt_vld;
   logic [IDX_W:0]    busy_cnt;

   rename_map #(.REG_N(REG_N), .IDX_W(IDX_W), .TAG_W(TAG_W), .CKPT_N(CKPT_N), .CKPT_W(CKPT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_tag(iss_tag),
      .cmt_valid(cmt_valid), .cmt_dst(cmt_dst), .cmt_tag(cmt_tag),
      .rs1(rs1), .rs2(rs2), .qj(qj), .qk(qk),
      .ckpt_save(ckpt_save), .ckpt_id(ckpt_id),
      .ckpt_restore(ckpt_restore), .rst_id(rst_id),
      .flush(flush), .ckpt_vld(ckpt_vld), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: plain arrays of tags, one table plus snapshots.
   int m [REG_N];
   int c [CKPT_N][REG_N];
   bit cv [CKPT_N];

   typedef struct {
      int iv, id, it;
      int cmv, cd, ct;
      int sv, sid;
      int rv, rid;
      int fl;
      int r1, r2;
      int eqj, eqk, ebusy, evld;
   } vec_t;
   vec_t vecs [20];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_busy();
      int n = 0;
      for (int r = 0; r < REG_N; r++) if (m[r] != 0) n++;
      return n;
   endfunction

   function automatic int model_vld();
      int v = 0;
      for (int s = 0; s < CKPT_N; s++) if (cv[s]) v += (1 << s);
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < REG_N; r++) m[r] = 0;
      for (int s = 0; s < CKPT_N; s++) begin
         cv[s] = 0;
         for (int r = 0; r < REG_N; r++) c[s][r] = 0;
      end
   endtask

   // Apply one clock edge worth of rename rules to the model.
   task automatic model_step();
      int nt [REG_N];
      bit restoring;
      int cd, ct;
      if (flush) begin
         model_reset();
         return;
      end
      cd = int'(cmt_dst);
      ct = int'(cmt_tag);
      restoring = ckpt_restore && cv[rst_id];
      for (int r = 0; r < REG_N; r++) nt[r] = restoring ? c[rst_id][r] : m[r];
      if (cmt_valid && nt[cd] == ct) nt[cd] = 0;
      if (!restoring && iss_valid && iss_dst != 0 && iss_tag != 0) nt[iss_dst] = int'(iss_tag);
      for (int s = 0; s < CKPT_N; s++)
         if (cmt_valid && cv[s] && c[s][cd] == ct) c[s][cd] = 0;
      if (restoring) cv[rst_id] = 0;
      else if (ckpt_save) begin
         cv[ckpt_id] = 1;
         for (int r = 0; r < REG_N; r++) c[ckpt_id][r] = nt[r];
      end
      for (int r = 0; r < REG_N; r++) m[r] = nt[r];
   endtask

   task automatic drive(input int iv, id, it, cmv, cd, ct, sv, sid, rv, rid, fl, r1, r2);
      iss_valid    = (iv != 0);
      iss_dst      = IDX_W'(id);
      iss_tag      = TAG_W'(it);
      cmt_valid    = (cmv != 0);
      cmt_dst      = IDX_W'(cd);
      cmt_tag      = TAG_W'(ct);
      ckpt_save    = (sv != 0);
      ckpt_id      = CKPT_W'(sid);
      ckpt_restore = (rv != 0);
      rst_id       = CKPT_W'(rid);
      flush        = (fl != 0);
      rs1          = IDX_W'(r1);
      rs2          = IDX_W'(r2);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, int'(rs1), int'(rs2));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_model(input string tag);
      check($sformatf("%s qj", tag), int'(qj), m[rs1]);
      check($sformatf("%s qk", tag), int'(qk), m[rs2]);
      check($sformatf("%s busy", tag), int'(busy_cnt), model_busy());
      check($sformatf("%s vld", tag), int'(ckpt_vld), model_vld());
   endtask

   initial begin
      //            iv id it  cv cd ct  sv sid rv rid fl r1 r2   qj qk busy vld
      vecs[0]  = '{1, 5, 3,  0, 0, 0,  0, 0,  0, 0,  0, 5, 0,   3, 0, 1, 0};
      vecs[1]  = '{0, 0, 0,  1, 5, 3,  0, 0,  0, 0,  0, 5, 0,   0, 0, 0, 0};
      vecs[2]  = '{1, 7, 2,  0, 0, 0,  0, 0,  0, 0,  0, 7, 0,   2, 0, 1, 0};
      vecs[3]  = '{1, 7, 6,  0, 0, 0,  0, 0,  0, 0,  0, 7, 0,   6, 0, 1, 0};
      vecs[4]  = '{0, 0, 0,  1, 7, 2,  0, 0,  0, 0,  0, 7, 0,   6, 0, 1, 0};
      vecs[5]  = '{1, 4, 1,  0, 0, 0,  0, 0,  0, 0,  0, 4, 7,   1, 6, 2, 0};
      vecs[6]  = '{1, 4, 5,  1, 4, 1,  0, 0,  0, 0,  0, 4, 7,   5, 6, 2, 0};
      vecs[7]  = '{1, 0, 9,  0, 0, 0,  0, 0,  0, 0,  0, 0, 4,   0, 5, 2, 0};
      vecs[8]  = '{1, 3, 2,  0, 0, 0,  0, 0,  0, 0,  0, 3, 0,   2, 0, 3, 0};
      vecs[9]  = '{1, 8, 4,  0, 0, 0,  1, 0,  0, 0,  0, 3, 8,   2, 4, 4, 1};
      vecs[10] = '{1, 3, 7,  0, 0, 0,  0, 0,  0, 0,  0, 3, 8,   7, 4, 4, 1};
      vecs[11] = '{1,10, 1,  0, 0, 0,  0, 0,  1, 0,  0, 3,10,   2, 0, 4, 0};
      vecs[12] = '{1, 9, 5,  0, 0, 0,  0, 0,  0, 0,  0, 9, 0,   5, 0, 5, 0};
      vecs[13] = '{0, 0, 0,  0, 0, 0,  1, 1,  0, 0,  0, 9, 3,   5, 2, 5, 2};
      vecs[14] = '{0, 0, 0,  1, 9, 5,  0, 0,  0, 0,  0, 9, 0,   0, 0, 4, 2};
      vecs[15] = '{0, 0, 0,  0, 0, 0,  0, 0,  1, 1,  0, 9, 8,   0, 4, 4, 0};
      vecs[16] = '{1,11, 3,  0, 0, 0,  0, 0,  1, 1,  0,11, 3,   3, 2, 5, 0};
      vecs[17] = '{0, 0, 0,  0, 0, 0,  1, 1,  0, 0,  0,11, 4,   3, 5, 5, 2};
      vecs[18] = '{1,12, 2,  0, 0, 0,  1, 0,  1, 1,  0,12,11,   0, 3, 5, 0};
      vecs[19] = '{1,13, 1,  0, 0, 0,  0, 0,  0, 0,  1, 7,13,   0, 0, 0, 0};

      model_reset();
      rs1 = 5'd5;
      #12;
      check("reset qj", int'(qj), 0);
      check("reset busy", int'(busy_cnt), 0);
      check("reset vld", int'(ckpt_vld), 0);
      rst_n = 1'b1;
      #1;

      // Directed vectors: expectations are hand-derived constants.
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].iv, vecs[i].id, vecs[i].it, vecs[i].cmv, vecs[i].cd, vecs[i].ct,
               vecs[i].sv, vecs[i].sid, vecs[i].rv, vecs[i].rid, vecs[i].fl, vecs[i].r1, vecs[i].r2);
         tick();
         $display("vec %0d: qj=%0d qk=%0d busy=%0d vld=%0d", i, qj, qk, busy_cnt, ckpt_vld);
         check($sformatf("vec%0d qj", i), int'(qj), vecs[i].eqj);
         check($sformatf("vec%0d qk", i), int'(qk), vecs[i].eqk);
         check($sformatf("vec%0d busy", i), int'(busy_cnt), vecs[i].ebusy);
         check($sformatf("vec%0d vld", i), int'(ckpt_vld), vecs[i].evld);
      end

      // Populate ten entries and both slots, then flush.
      for (int i = 1; i <= 10; i++) begin
         drive(1, i, (i % 15) + 1, 0, 0, 0, 0, 0, 0, 0, 0, i, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0); tick();
      drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 3, 0); tick();
      $display("populated: busy=%0d vld=%0d", busy_cnt, ckpt_vld);
      check("populate busy", int'(busy_cnt), 10);
      check("populate vld", int'(ckpt_vld), 3);
      drive(1, 20, 3, 0, 0, 0, 1, 0, 0, 0, 1, 3, 20); tick();
      $display("flush: busy=%0d vld=%0d", busy_cnt, ckpt_vld);
      check("flush busy", int'(busy_cnt), 0);
      check("flush vld", int'(ckpt_vld), 0);
      check("flush qj", int'(qj), 0);
      check("flush qk", int'(qk), 0);

      // Asynchronous reset between edges with a save pending.
      for (int i = 1; i <= 4; i++) begin
         drive(1, i, i, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0); tick();
      check("pre-reset busy", int'(busy_cnt), 4);
      drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 2, 0);
      #2;
      rst_n = 1'b0;
      #1;
      $display("async reset: qj=%0d busy=%0d vld=%0d", qj, busy_cnt, ckpt_vld);
      check("async qj", int'(qj), 0);
      check("async busy", int'(busy_cnt), 0);
      check("async vld", int'(ckpt_vld), 0);
      model_reset();
      idle();
      rst_n = 1'b1;
      tick();
      check_model("post-reset");

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         int id, cd, ct, rid;
         id  = int'($urandom_range(0, REG_N - 1));
         cd  = ($urandom_range(0, 7) == 0) ? id : int'($urandom_range(0, REG_N - 1));
         rid = int'($urandom_range(0, CKPT_N - 1));
         case ($urandom_range(0, 3))
            0:       ct = int'($urandom_range(0, 15));
            1:       ct = c[rid][cd];
            default: ct = m[cd];
         endcase
         drive(int'($urandom_range(0, 3) != 0), id, int'($urandom_range(0, 15)),
               int'($urandom_range(0, 1)), cd, ct,
               int'($urandom_range(0, 5) == 0), int'($urandom_range(0, CKPT_N - 1)),
               int'($urandom_range(0, 5) == 0), rid,
               int'($urandom_range(0, 199) == 0),
               int'($urandom_range(0, REG_N - 1)), int'($urandom_range(0, REG_N - 1)));
         tick();
         check_model($sformatf("rand%0d", n));
      end

      // Full-table sweep of the final state.
      idle();
      for (int i = 0; i < REG_N; i++) begin
         rs1 = IDX_W'(i);
         rs2 = IDX_W'(REG_N - 1 - i);
         #1;
         check($sformatf("sweep qj r%0d", i), int'(qj), m[i]);
         check($sformatf("sweep qk r%0d", REG_N - 1 - i), int'(qk), m[REG_N - 1 - i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
